sobel_window_buffer: RTL and testbench

Upstream stage of the Sobel gradient datapath. Accepts a raster-order 8-bit grayscale pixel stream, keeps the two previous image rows in line buffers, and presents a registered 3x3 neighbourhood P0..P8 plus a one-cycle `start_calculations` strobe. The horizontal and vertical gradient stages consume these outputs directly. Only fully interior windows are emitted; border pixels produce no window.

---
 rtl/sobel_window_buffer.sv | 155 +++++++++++++++
 tb/tb_sobel_window_buffer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_window_buffer.sv
// -----------------------------------------------------------------------------
// sobel_window_buffer
//
// Front end of the Sobel gradient datapath. Takes a raster-order 8-bit
// grayscale pixel stream, keeps the two previous image rows in line buffers
// and presents a registered 3x3 neighbourhood to the gradient stages.
// Only fully interior windows are flagged; border pixels produce no window.
//
// Parameters
//   IMG_WIDTH           pixels per row   (>= 3)
//   IMG_HEIGHT          rows per frame   (>= 3)
//
// Ports
//   clk                 single clock, all state changes on the rising edge
//   rst                 asynchronous active-high reset
//   sof                 start of frame, qualifies pix_in when pix_valid = 1
//   pix_valid           pixel accepted this cycle (no backpressure)
//   pix_in[7:0]         unsigned pixel
//   P0..P8[7:0]         window: P0 P1 P2 top row, P3 P4 P5 middle row,
//                       P6 P7 P8 bottom row, P8 is the newest pixel
//   start_calculations  one-cycle strobe, P0..P8 hold a valid interior window
//   frame_done          one-cycle strobe after the last pixel of a frame
// -----------------------------------------------------------------------------
module sobel_window_buffer #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sof,
    input  logic       pix_valid,
    input  logic [7:0] pix_in,
    output logic [7:0] P0,
    output logic [7:0] P1,
    output logic [7:0] P2,
    output logic [7:0] P3,
    output logic [7:0] P4,
    output logic [7:0] P5,
    output logic [7:0] P6,
    output logic [7:0] P7,
    output logic [7:0] P8,
    output logic       start_calculations,
    output logic       frame_done
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

    // Position of the next pixel to be accepted.
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;

    // Position actually used for the pixel on pix_in this cycle (sof
    // overrides the counters) and the position that follows it.
    logic [COL_W-1:0] cur_col;
    logic [ROW_W-1:0] cur_row;
    logic [COL_W-1:0] next_col;
    logic [ROW_W-1:0] next_row;

    // lb_top holds row r-2, lb_mid holds row r-1, both indexed by column.
    logic [7:0] lb_top [IMG_WIDTH];
    logic [7:0] lb_mid [IMG_WIDTH];

    logic [7:0] top_pix;
    logic [7:0] mid_pix;

    logic interior;
    logic last_pix;

    // Resolve the current position and compute where the stream goes next.
    always_comb begin
        cur_col = sof ? {COL_W{1'b0}} : col;
        cur_row = sof ? {ROW_W{1'b0}} : row;

        if (cur_col == COL_LAST) begin
            next_col = {COL_W{1'b0}};
            next_row = (cur_row == ROW_LAST) ? {ROW_W{1'b0}} : cur_row + ROW_W'(1);
        end else begin
            next_col = cur_col + COL_W'(1);
            next_row = cur_row;
        end

        top_pix = lb_top[cur_col];
        mid_pix = lb_mid[cur_col];

        // Requiring col >= 2 keeps a window from straddling a row wrap;
        // row >= 2 hides line-buffer contents left over from earlier frames.
        interior = (cur_row >= ROW_TWO) && (cur_col >= COL_TWO);
        last_pix = (cur_row == ROW_LAST) && (cur_col == COL_LAST);
    end

    // Line buffers are plain memories with no reset: the interior mask
    // guarantees stale contents never reach a flagged window.
    always_ff @(posedge clk) begin
        if (pix_valid) begin
            lb_top[cur_col] <= mid_pix;
            lb_mid[cur_col] <= pix_in;
        end
    end

    // Position counters advance only on accepted pixels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= {COL_W{1'b0}};
            row <= {ROW_W{1'b0}};
        end else if (pix_valid) begin
            col <= next_col;
            row <= next_row;
        end
    end

    // Window shift registers: each row of the window shifts left and takes
    // the new column from the line buffers and the incoming pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            P0 <= 8'd0;
            P1 <= 8'd0;
            P2 <= 8'd0;
            P3 <= 8'd0;
            P4 <= 8'd0;
            P5 <= 8'd0;
            P6 <= 8'd0;
            P7 <= 8'd0;
            P8 <= 8'd0;
        end else if (pix_valid) begin
            P0 <= P1;
            P1 <= P2;
            P2 <= top_pix;
            P3 <= P4;
            P4 <= P5;
            P5 <= mid_pix;
            P6 <= P7;
            P7 <= P8;
            P8 <= pix_in;
        end
    end

    // Strobes are registered and therefore line up with the window they
    // describe; any idle cycle drops them back to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_calculations <= 1'b0;
            frame_done         <= 1'b0;
        end else begin
            start_calculations <= pix_valid && interior;
            frame_done         <= pix_valid && last_pix;
        end
    end

endmodule

// File: tb/tb_sobel_window_buffer.sv
// -----------------------------------------------------------------------------
// tb_sobel_window_buffer
//
// Bench for sobel_window_buffer with a 4x4 image. A frame-level model keeps
// the pixels of the current frame in a 2-D array and derives each expected
// window directly from image coordinates; a compare process checks the DUT
// against it on every falling edge. A few literal windows pin the model.
// -----------------------------------------------------------------------------
module tb_sobel_window_buffer;

    localparam int W = 4;
    localparam int H = 4;

    logic       clk;
    logic       rst;
    logic       sof;
    logic       pix_valid;
    logic [7:0] pix_in;
    logic [7:0] P0, P1, P2, P3, P4, P5, P6, P7, P8;
    logic       start_calculations;
    logic       frame_done;

    sobel_window_buffer #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .sof               (sof),
        .pix_valid         (pix_valid),
        .pix_in            (pix_in),
        .P0                (P0),
        .P1                (P1),
        .P2                (P2),
        .P3                (P3),
        .P4                (P4),
        .P5                (P5),
        .P6                (P6),
        .P7                (P7),
        .P8                (P8),
        .start_calculations(start_calculations),
        .frame_done        (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks_done;
    int checks_failed;
    bit checking;

    // Model state
    logic [7:0] img [H][W];
    logic [7:0] exp_p [9];
    bit         exp_known;
    logic [7:0] exp_last;
    bit         last_known;
    logic       exp_start;
    logic       exp_done;
    int         m_row;
    int         m_col;
    int         frame_wins;
    logic [7:0] first_win [9];
    logic [7:0] last_win [9];

    // Counts of DUT strobes seen by the compare process
    int dut_strobes;
    int dut_dones;

    logic [7:0] dut_p [9];
    assign dut_p[0] = P0;
    assign dut_p[1] = P1;
    assign dut_p[2] = P2;
    assign dut_p[3] = P3;
    assign dut_p[4] = P4;
    assign dut_p[5] = P5;
    assign dut_p[6] = P6;
    assign dut_p[7] = P7;
    assign dut_p[8] = P8;

    task automatic checkOutput(input string name, input logic [7:0] actual,
                               input logic [7:0] expected);
        checks_done++;
        if (actual !== expected) begin
            checks_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Frame-level model: the window for a pixel at (r,c) is simply the 3x3
    // block of the current frame's image ending at (r,c).
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 9; i++) exp_p[i] = 8'd0;
            exp_known  = 1'b1;
            last_known = 1'b0;
            exp_start  = 1'b0;
            exp_done   = 1'b0;
            m_row      = 0;
            m_col      = 0;
            frame_wins = 0;
        end else begin
            exp_start = 1'b0;
            exp_done  = 1'b0;
            if (pix_valid) begin
                int r;
                int c;
                r = sof ? 0 : m_row;
                c = sof ? 0 : m_col;
                if (r == 0 && c == 0) frame_wins = 0;
                img[r][c]  = pix_in;
                exp_last   = pix_in;
                last_known = 1'b1;
                if (r >= 2 && c >= 2) begin
                    for (int k = 0; k < 3; k++)
                        for (int j = 0; j < 3; j++)
                            exp_p[3*k+j] = img[r-2+k][c-2+j];
                    exp_known = 1'b1;
                    exp_start = 1'b1;
                    if (frame_wins == 0) first_win = exp_p;
                    last_win = exp_p;
                    frame_wins++;
                end else begin
                    exp_known = 1'b0;
                end
                exp_done = (r == H-1) && (c == W-1);
                if (c == W-1) begin
                    m_col = 0;
                    m_row = (r == H-1) ? 0 : r + 1;
                end else begin
                    m_col = c + 1;
                    m_row = r;
                end
            end
        end
    end

    // Compare process: DUT versus model on every falling edge.
    always @(negedge clk) begin
        if (checking) begin
            checkOutput("start_calculations", {7'd0, start_calculations}, {7'd0, exp_start});
            checkOutput("frame_done", {7'd0, frame_done}, {7'd0, exp_done});
            if (exp_known)
                for (int i = 0; i < 9; i++)
                    checkOutput($sformatf("P%0d", i), dut_p[i], exp_p[i]);
            if (last_known && !rst)
                checkOutput("P8_newest", P8, exp_last);
            if (start_calculations === 1'b1) dut_strobes++;
            if (frame_done === 1'b1) dut_dones++;
        end
    end

    task automatic applyStimulus(input logic v, input logic s, input logic [7:0] p);
        @(posedge clk);
        #2;
        pix_valid = v;
        sof       = s;
        pix_in    = p;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'd0);
    endtask

    task automatic sendFrame(input bit invert, input bit toggle, input bit use_sof);
        for (int i = 0; i < W*H; i++) begin
            logic [7:0] v;
            v = invert ? 8'(255 - i) : 8'(i);
            applyStimulus(1'b1, use_sof && (i == 0), v);
            if (toggle) applyStimulus(1'b0, 1'b0, 8'd0);
        end
    endtask

    task automatic checkWindow(input string name, input logic [7:0] got [9],
                               input logic [7:0] want [9]);
        for (int i = 0; i < 9; i++)
            checkOutput($sformatf("%s_P%0d", name, i), got[i], want[i]);
    endtask

    task automatic checkCounts(input string name, input int s0, input int d0,
                               input int want_s, input int want_d);
        checkOutput({name, "_strobes"}, 8'(dut_strobes - s0), 8'(want_s));
        checkOutput({name, "_done"}, 8'(dut_dones - d0), 8'(want_d));
    endtask

    initial begin
        logic [7:0] win_first [9];
        logic [7:0] win_last [9];
        logic [7:0] win_inv [9];
        int s0;
        int d0;

        win_first = '{8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10};
        win_last  = '{8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11, 8'd13, 8'd14, 8'd15};
        win_inv   = '{8'd255, 8'd254, 8'd253, 8'd251, 8'd250, 8'd249, 8'd247, 8'd246, 8'd245};

        checks_done   = 0;
        checks_failed = 0;
        dut_strobes   = 0;
        dut_dones     = 0;
        checking      = 1'b0;
        sof           = 1'b0;
        pix_valid     = 1'b0;
        pix_in        = 8'd0;
        rst           = 1'b0;
        #1 rst        = 1'b1;
        checking      = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // Reset state
        checkOutput("reset_P4", P4, 8'd0);
        checkOutput("reset_start", {7'd0, start_calculations}, 8'd0);

        // Continuous frame
        $display("[TB] continuous 4x4 frame");
        s0 = dut_strobes; d0 = dut_dones;
        sendFrame(1'b0, 1'b0, 1'b1);
        idle(2);
        checkCounts("continuous", s0, d0, 4, 1);
        checkWindow("continuous_first", first_win, win_first);
        checkWindow("continuous_last", last_win, win_last);

        // Toggling pix_valid
        $display("[TB] toggling pix_valid");
        s0 = dut_strobes; d0 = dut_dones;
        sendFrame(1'b0, 1'b1, 1'b1);
        idle(2);
        checkCounts("toggle", s0, d0, 4, 1);
        checkWindow("toggle_first", first_win, win_first);
        checkWindow("toggle_last", last_win, win_last);

        // Reset mid-row 2, then a frame without sof
        $display("[TB] reset mid-frame");
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, i == 0, 8'(100 + i));
        @(posedge clk);
        #2;
        pix_valid = 1'b0;
        rst       = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        checkOutput("midreset_P8", P8, 8'd0);
        s0 = dut_strobes; d0 = dut_dones;
        sendFrame(1'b0, 1'b0, 1'b0);
        idle(2);
        checkCounts("after_reset", s0, d0, 4, 1);
        checkWindow("after_reset_first", first_win, win_first);

        // sof aborts a partial frame
        $display("[TB] sof mid-frame");
        s0 = dut_strobes; d0 = dut_dones;
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, i == 0, 8'(200 + i));
        sendFrame(1'b0, 1'b0, 1'b1);
        idle(2);
        checkCounts("sof_abort", s0, d0, 4, 1);
        checkWindow("sof_abort_first", first_win, win_first);
        checkWindow("sof_abort_last", last_win, win_last);

        // Back-to-back frames, second one inverted
        $display("[TB] back-to-back frames");
        s0 = dut_strobes; d0 = dut_dones;
        sendFrame(1'b0, 1'b0, 1'b1);
        sendFrame(1'b1, 1'b0, 1'b1);
        idle(2);
        checkCounts("b2b", s0, d0, 8, 2);
        checkWindow("b2b_second_first", first_win, win_inv);

        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", checks_done, checks_failed);
        $finish;
    end

endmodule
